// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch prefetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// addr_t / instr_t   : default 32-bit PC and instruction words
// fetch_entry_t      : one prefetch-queue entry, {pc_plus4, instr}
// INSTR_BYTES        : PC increment between sequential fetches
package if_pkg;

   localparam int unsigned INSTR_BYTES = 4;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] instr_t;

   typedef struct packed {
      addr_t  pc_plus4;
      instr_t instr;
   } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Synchronous DEPTH-entry FIFO with flush; element type is a type parameter.
// Latency: a push is visible at rdata/count on the next cycle.
// Backpressure: none internally; the caller must never push when full or pop when empty.
//
// Ports: clk, rst (sync, active-high), push/wdata, pop, flush (clears contents),
//        rdata (head entry, meaningful only when count != 0), count (0..DEPTH).
module if_fetch_queue
   import if_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = fetch_entry_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  T                       wdata,
   input  logic                   pop,
   input  logic                   flush,
   output T                       rdata,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);

   T           mem [DEPTH];
   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;

   // Pointers carry one extra bit so full (DEPTH) and empty (0) differ.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset; stale slots are never read as valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[PW-1:0]] <= wdata;
   end

   assign count = wr_ptr - rd_ptr;
   assign rdata = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         assert (!(push && !pop && count == (PW+1)'(DEPTH)));
         assert (!(pop && count == '0));
      end
   end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction fetch with a DEPTH-entry prefetch queue and up to DEPTH fetches in flight.
// Latency: grant t, response t+L, out_valid t+L+1 (t+L with IF_PREFETCH_BYPASS_EN).
// Backpressure: out_ready low fills the queue; imem_req drops once queue+inflight reach DEPTH.
//
// Ports: clk, rst (sync, active-high); branch_taken/branch_address redirect;
//        imem_req/imem_addr/imem_gnt request side, imem_rvalid/imem_rdata in-order responses;
//        out_valid/out_ready/out_pc (fetch address + 4)/out_instr towards ID.
// Build option: IF_PREFETCH_BYPASS_EN forwards a response straight to the outputs when the queue is empty.
module if_prefetch_stage
   import if_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                INSTR_W  = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_address,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ADDR_W-1:0]  out_pc,
   output logic [INSTR_W-1:0] out_instr
);

   localparam int CW = $clog2(DEPTH) + 1;

   typedef logic [ADDR_W-1:0] pc_t;
   typedef struct packed {
      logic [ADDR_W-1:0]  pc_plus4;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   pc_t           fetch_pc;
   pc_t           req_addr;
   logic [CW-1:0] q_count;
   logic [CW-1:0] inflight;
   logic [CW-1:0] discard;
   entry_t        head;
   entry_t        resp_entry;
   logic          grant;
   logic          resp_keep;
   logic          q_empty;
   logic          q_push;
   logic          q_pop;
   logic          bypass;

   // Credit rule: every outstanding fetch has a reserved queue slot.
   assign imem_req  = !rst && !branch_taken && ((q_count + inflight) < CW'(DEPTH));
   assign imem_addr = fetch_pc;
   assign grant     = imem_req && imem_gnt;

   // Responses belonging to requests issued before the last redirect are dropped,
   // as is any response arriving in the redirect cycle itself.
   assign resp_keep  = imem_rvalid && (discard == '0) && !branch_taken && !rst;
   assign q_empty    = (q_count == '0);
   assign resp_entry = '{pc_plus4: req_addr + ADDR_W'(INSTR_BYTES), instr: imem_rdata};

`ifdef IF_PREFETCH_BYPASS_EN
   assign bypass = resp_keep && q_empty;
`else
   assign bypass = 1'b0;
`endif

   assign out_valid = !rst && !branch_taken && (!q_empty || bypass);
   assign out_pc    = !out_valid ? '0 : (bypass ? resp_entry.pc_plus4 : head.pc_plus4);
   assign out_instr = !out_valid ? '0 : (bypass ? resp_entry.instr    : head.instr);

   assign q_pop  = out_valid && out_ready && !q_empty;
   assign q_push = resp_keep && !(bypass && out_ready);

   // Request addresses in issue order; its occupancy is the in-flight count.
   if_fetch_queue #(
      .DEPTH (DEPTH),
      .T     (pc_t)
   ) u_addr_q (
      .clk   (clk),
      .rst   (rst),
      .push  (grant),
      .wdata (fetch_pc),
      .pop   (imem_rvalid && !rst),
      .flush (1'b0),
      .rdata (req_addr),
      .count (inflight)
   );

   if_fetch_queue #(
      .DEPTH (DEPTH),
      .T     (entry_t)
   ) u_data_q (
      .clk   (clk),
      .rst   (rst),
      .push  (q_push),
      .wdata (resp_entry),
      .pop   (q_pop),
      .flush (branch_taken),
      .rdata (head),
      .count (q_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         discard  <= '0;
      end else if (branch_taken) begin
         fetch_pc <= branch_address;
         // No grant can occur this cycle; a response this cycle retires one in-flight fetch.
         discard  <= inflight - CW'(imem_rvalid);
      end else begin
         if (grant) fetch_pc <= fetch_pc + ADDR_W'(INSTR_BYTES);
         if (imem_rvalid && discard != '0) discard <= discard - 1'b1;
      end
   end

   // Memory must never answer more fetches than were granted.
   always_ff @(posedge clk) begin
      if (!rst) assert (!(imem_rvalid && inflight == '0));
   end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Randomised bench for if_prefetch_stage against a request/epoch reference model.
// Latency: n/a.
// Backpressure: out_ready and imem_gnt are randomised per phase.
module tb_if_prefetch_stage;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
`ifdef IF_PREFETCH_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_address = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;

   always #5 clk = ~clk;

   if_prefetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .branch_taken   (branch_taken),
      .branch_address (branch_address),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr)
   );

   // A granted fetch: address, cycle its response is due, redirect epoch it was issued in.
   typedef struct {
      logic [31:0] addr;
      int          due;
      int          ep;
   } req_t;
   typedef struct {
      logic [31:0] pc4;
      logic [31:0] ins;
   } exp_t;

   req_t        pend[$];
   exp_t        mq[$];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          epoch = 0;
   logic [31:0] mpc = RESET_PC;
   int          grants, hs, first_g, first_h;
   bit          after_br;
   logic [31:0] br_tgt;
   int          gnt_pct, rdy_pct, lat_lo, lat_hi;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic run_cycle();
      req_t r;
      bit   keep;
      bit   exp_v;
      imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
      out_ready   = ($urandom_range(0, 99) < rdy_pct);
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(pend[0].addr);
      end
      @(negedge clk);
      if (rst) begin
         check("rst_req",   32'(imem_req),  32'h0);
         check("rst_valid", 32'(out_valid), 32'h0);
         check("rst_pc",    out_pc,         32'h0);
         check("rst_instr", out_instr,      32'h0);
         pend.delete();
         mq.delete();
         mpc      = RESET_PC;
         after_br = 1'b0;
         grants   = 0;
         hs       = 0;
         first_g  = -1;
         first_h  = -1;
      end else begin
         check("req", 32'(imem_req),
               32'(!branch_taken && (mq.size() + pend.size() < DEPTH)));
         if (imem_req) check("addr", imem_addr, mpc);
         keep = 1'b0;
         if (imem_rvalid) begin
            r    = pend.pop_front();
            keep = !branch_taken && (r.ep == epoch);
         end
         exp_v = !branch_taken && (mq.size() > 0 || (BYPASS && keep));
         if (keep) mq.push_back('{pc4: r.addr + 32'd4, ins: mem_word(r.addr)});
         check("valid", 32'(out_valid), 32'(exp_v));
         if (out_valid && mq.size() > 0) begin
            check("out_pc",    out_pc,    mq[0].pc4);
            check("out_instr", out_instr, mq[0].ins);
            if (out_ready) begin
               if (after_br) check("redir_pc", out_pc, br_tgt + 32'd4);
               after_br = 1'b0;
               void'(mq.pop_front());
               hs++;
               if (first_h < 0) first_h = cyc;
            end
         end
         if (imem_req && imem_gnt) begin
            pend.push_back('{addr: mpc, due: cyc + int'($urandom_range(lat_lo, lat_hi)), ep: epoch});
            mpc = mpc + 32'd4;
            grants++;
            if (first_g < 0) first_g = cyc;
         end
         if (branch_taken) begin
            mq.delete();
            epoch++;
            mpc      = branch_address;
            after_br = 1'b1;
            br_tgt   = branch_address;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      branch_taken = 1'b0;
      gnt_pct      = 0;
      rdy_pct      = 0;
      repeat (3) run_cycle();
      rst = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] target);
      branch_taken   = 1'b1;
      branch_address = target;
      run_cycle();
      branch_taken   = 1'b0;
   endtask

   initial begin
      lat_lo = 1;
      lat_hi = 1;

      // Streaming: gnt=1, L=1, out_ready=1.
      do_reset();
      gnt_pct = 100; rdy_pct = 100; lat_lo = 1; lat_hi = 1;
      repeat (40) run_cycle();
      check("latency",    32'(first_h - first_g), BYPASS ? 32'd1 : 32'd2);
      check("throughput", 32'(hs),                BYPASS ? 32'd39 : 32'd38);

      // Stall ID: exactly DEPTH fetches, then request withdrawn; drain in order.
      do_reset();
      gnt_pct = 100; rdy_pct = 0;
      repeat (10) run_cycle();
      check("full_grants", 32'(grants),   32'd4);
      check("full_req",    32'(imem_req), 32'h0);
      gnt_pct = 0; rdy_pct = 100;
      repeat (8) run_cycle();
      check("drain_hs", 32'(hs), 32'd4);

      // Redirect with three fetches in flight.
      do_reset();
      gnt_pct = 100; rdy_pct = 100; lat_lo = 6; lat_hi = 6;
      repeat (3) run_cycle();
      check("inflight3", 32'(grants), 32'd3);
      redirect(32'h100);
      repeat (20) run_cycle();

      // Redirect in a cycle that also carries a response and a pop.
      do_reset();
      gnt_pct = 100; rdy_pct = 100; lat_lo = 1; lat_hi = 1;
      repeat (10) run_cycle();
      redirect(32'h200);
      repeat (10) run_cycle();

      // Address wrap at the top of the address space.
      do_reset();
      gnt_pct = 100; rdy_pct = 100; lat_lo = 2; lat_hi = 2;
      repeat (4) run_cycle();
      redirect(32'hFFFF_FFFC);
      repeat (20) run_cycle();

      // Random grant stalls, fixed L=3, random ready and redirects.
      do_reset();
      gnt_pct = 50; rdy_pct = 70; lat_lo = 3; lat_hi = 3;
      for (int i = 0; i < 1500; i++) begin
         branch_taken   = ($urandom_range(0, 99) < 4);
         branch_address = $urandom() & 32'hFFFF_FFFC;
         run_cycle();
      end
      branch_taken = 1'b0;

      // Random latency 1..5 with one reset mid-stream.
      gnt_pct = 70; rdy_pct = 60; lat_lo = 1; lat_hi = 5;
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) begin
            do_reset();
            gnt_pct = 70; rdy_pct = 60;
         end
         branch_taken   = ($urandom_range(0, 99) < 3);
         branch_address = $urandom() & 32'hFFFF_FFFC;
         run_cycle();
      end

      // Let everything outstanding come back and drain.
      branch_taken = 1'b0;
      gnt_pct = 0; rdy_pct = 100;
      repeat (30) run_cycle();
      check("drained", 32'(mq.size() + pend.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/if_prefetch_stage.md
# if_prefetch_stage

Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue, a pipelined request/grant/response instruction-memory port, and a valid/ready output handshake to the ID stage. It replaces the single-register, freeze-driven fetch: it keeps up to DEPTH fetches in flight, flushes wrong-path work on a branch redirect, and presents PC+4 alongside each instruction. It sits between the instruction memory and the IF/ID pipeline register.

## Interface
- ADDR_W, 32, PC/address width
- INSTR_W, 32, instruction width
- DEPTH, 4, queue entries and max outstanding fetches; power of two, ≥2
- RESET_PC, 0, first fetch address after reset
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- branch_taken  in  1  redirect request from EXE
- branch_address  in  ADDR_W  redirect target
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  fetch address (word aligned)
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  in-order response valid
- imem_rdata  in  INSTR_W  response instruction
- out_valid  out  1  head instruction valid to ID
- out_ready  in  1  ID accepts head (replaces ~freeze)
- out_pc  out  ADDR_W  fetch address of head + 4
- out_instr  out  INSTR_W  head instruction

## Operation
- State: fetch_pc, queue count, inflight (0..DEPTH), discard (0..DEPTH).
- imem_req = !rst && !branch_taken && (count + inflight < DEPTH); imem_addr = fetch_pc.
- Grant (imem_req && imem_gnt): inflight+1, fetch_pc += 4, width wraps modulo 2^ADDR_W.
- Response (imem_rvalid): inflight−1; if discard>0, discard−1 and data dropped; else push {imem_addr_of_request+4, rdata}. Queue stores PC+4 per entry.
- Pop on out_valid && out_ready.
- Grant, response and pop in the same cycle all apply; the credit rule guarantees no push to a full queue.
- Branch (branch_taken=1) overrides all: queue emptied, fetch_pc ← branch_address, discard ← inflight after this cycle's grant/response accounting (no grant occurs, since imem_req=0), out_valid forced 0 combinationally. A response arriving in the branch cycle is dropped.
- Memory must never return more responses than were granted; an unsolicited rvalid is a protocol error (assertion).
- Request held with stable address until granted; it is withdrawn only by branch_taken or rst.

## Timing
- Reset: imem_req=0, out_valid=0, out_pc=0, out_instr=0, fetch_pc=RESET_PC, count=inflight=discard=0. Reset mid-operation drops everything; later responses to pre-reset requests are not permitted (memory is reset with the core).
- First imem_req in the cycle after rst deasserts.
- Latency: grant cycle t, response t+L, out_valid at t+L+1 (registered queue).
- Throughput: one instruction/cycle when L+1 ≤ DEPTH and out_ready held high.
- Redirect: first target request in the cycle after branch_taken.

## Configuration
- IF_PREFETCH_BYPASS_EN defined: when queue is empty and a non-discarded response arrives, out_valid/out_instr/out_pc driven combinationally from the response the same cycle; if out_ready, the entry is not pushed. Latency becomes t+L.
- Undefined: all responses go through the queue; no combinational rdata→out path.

## Structure
- Package if_pkg: addr_t, instr_t, fetch_entry_t {pc_plus4, instr}, INSTR_BYTES=4.
- Sub-module if_fetch_queue: synchronous DEPTH-entry FIFO of fetch_entry_t with push, pop, flush, count; wrap-around pointers with an extra bit for full/empty.
- Outstanding-address FIFO (DEPTH entries) tracks request addresses for PC+4 tagging; reuse if_fetch_queue.

## Test plan
- Reset, gnt=1, L=1, out_ready=1 → imem_addr 0,4,8…; out_pc 4,8,12… with matching instr, one per cycle after ramp.
- out_ready=0 for 10 cycles, L=1 → exactly 4 fetches granted, imem_req drops, queue full; on release, 4 instructions drain in order, no loss/duplication.
- 3 fetches in flight, branch_taken to 0x100 → those 3 responses discarded, next out_pc=0x104, no wrong-path out_valid.
- Branch in the same cycle as rvalid and pop → response dropped, queue empty next cycle, imem_addr=target.
- gnt stalls randomly with L=3 → imem_addr stable while ungranted; order preserved.
- fetch_pc=0xFFFFFFFC → next imem_addr 0x0, out_pc 0x0; with IF_PREFETCH_BYPASS_EN, empty-queue response appears on out_valid same cycle.
